// File: rtl/fp_divider.sv
// Multi-cycle IEEE 754 divider (FDIV.S / FDIV.D). The mantissa quotient comes from a
// radix-2 restoring divider that produces one bit per cycle. Subnormal inputs are flushed to zero.
module fp_divider #(
  parameter int FLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      rounding_mode,
  input  logic [FLEN-1:0] operand_a,
  input  logic [FLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [FLEN-1:0] result,
  output logic            flag_nv,
  output logic            flag_dz,
  output logic            flag_of,
  output logic            flag_uf,
  output logic            flag_nx
);
  localparam int EW      = (FLEN == 64) ? 11 : 8;
  localparam int MW      = (FLEN == 64) ? 52 : 23;
  localparam int BIAS    = (1 << (EW - 1)) - 1;
  localparam int MAX_EXP = (1 << EW) - 1;
  localparam int QW      = MW + 4;
  localparam int RW      = MW + 2;
  localparam int XW      = EW + 2;
  localparam int CW      = $clog2(QW);
  localparam logic [CW-1:0]        LAST_ITER = CW'(QW - 1);
  localparam logic signed [XW-1:0] BIAS_X    = XW'(BIAS);
  localparam logic signed [XW-1:0] MAX_EXP_X = XW'(MAX_EXP);
  localparam logic signed [XW-1:0] ONE_X     = XW'(1);
  localparam logic [FLEN-1:0]      QNAN      = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  // Handshake: start is taken only in IDLE (operands and rounding mode are latched, flags cleared);
  // busy is high from UNPACK through ROUND; done is high for exactly the one cycle spent in DONE,
  // and result/flags are valid from then until the next accepted start.
  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_DIVIDE, S_NORMALIZE, S_ROUND, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [FLEN-1:0]        op_a, op_b;
  logic [2:0]             rm_q;
  logic                   sign_q;
  logic signed [XW-1:0]   exp_q;
  logic [MW:0]            man_b;
  logic [RW-1:0]          rem;
  logic [QW-1:0]          quo;
  logic [CW-1:0]          iter;
  logic [MW-1:0]          mant;
  logic                   guard, rnd, sticky;

  // Operand classification of the latched operands
  logic [EW-1:0] exp_a, exp_b;
  logic [MW-1:0] frac_a, frac_b;
  logic          sign_x, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic signed [XW-1:0] exp_diff;

  assign exp_a    = op_a[FLEN-2:MW];
  assign exp_b    = op_b[FLEN-2:MW];
  assign frac_a   = op_a[MW-1:0];
  assign frac_b   = op_b[MW-1:0];
  assign sign_x   = op_a[FLEN-1] ^ op_b[FLEN-1];
  assign a_nan    = (&exp_a) && (|frac_a);
  assign b_nan    = (&exp_b) && (|frac_b);
  assign a_snan   = a_nan && !frac_a[MW-1];
  assign b_snan   = b_nan && !frac_b[MW-1];
  assign a_inf    = (&exp_a) && !(|frac_a);
  assign b_inf    = (&exp_b) && !(|frac_b);
  assign a_zero   = (exp_a == '0);
  assign b_zero   = (exp_b == '0);
  assign exp_diff = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + BIAS_X;

  logic            spec_hit, spec_nv, spec_dz;
  logic [FLEN-1:0] spec_res;

  always_comb begin
    spec_hit = 1'b1;
    spec_nv  = 1'b0;
    spec_dz  = 1'b0;
    spec_res = '0;
    if (a_snan || b_snan) begin
      spec_res = QNAN;
      spec_nv  = 1'b1;
    end else if (a_nan || b_nan) begin
      spec_res = QNAN;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = QNAN;
      spec_nv  = 1'b1;
    end else if (a_inf) begin
      spec_res = {sign_x, {EW{1'b1}}, {MW{1'b0}}};
    end else if (b_zero) begin
      spec_res = {sign_x, {EW{1'b1}}, {MW{1'b0}}};
      spec_dz  = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_res = {sign_x, {(FLEN-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // One restoring step: subtract when the remainder covers the divisor, then shift
  logic          rem_ge;
  logic [RW-1:0] rem_sub;
  assign rem_ge  = (rem >= {1'b0, man_b});
  assign rem_sub = rem_ge ? (rem - {1'b0, man_b}) : rem;

  logic                 inexact, inc, ovf_inf;
  logic [MW:0]          mant_sum;
  logic signed [XW-1:0] exp_rnd;
  logic [FLEN-1:0]      rnd_res;
  logic                 rnd_of, rnd_uf, rnd_nx;

  always_comb begin
    inexact = guard | rnd | sticky;
    inc     = 1'b0;
    ovf_inf = 1'b0;
    case (rm_q)
      3'b000:  begin inc = guard & (rnd | sticky | mant[0]); ovf_inf = 1'b1; end
      3'b010:  begin inc = sign_q & inexact;                 ovf_inf = sign_q; end
      3'b011:  begin inc = !sign_q & inexact;                ovf_inf = !sign_q; end
      3'b100:  begin inc = guard;                            ovf_inf = 1'b1; end
      default: begin inc = 1'b0;                             ovf_inf = 1'b0; end
    endcase
    mant_sum = {1'b0, mant} + {{MW{1'b0}}, inc};
    exp_rnd  = exp_q + $signed({{(XW-1){1'b0}}, mant_sum[MW]});
    rnd_of   = 1'b0;
    rnd_uf   = 1'b0;
    rnd_nx   = inexact;
    if (exp_q < ONE_X) begin
      rnd_res = {sign_q, {(FLEN-1){1'b0}}};
      rnd_uf  = 1'b1;
      rnd_nx  = 1'b1;
    end else if (exp_rnd >= MAX_EXP_X) begin
      rnd_res = ovf_inf ? {sign_q, {EW{1'b1}}, {MW{1'b0}}}
                        : {sign_q, {(EW-1){1'b1}}, 1'b0, {MW{1'b1}}};
      rnd_of  = 1'b1;
      rnd_nx  = 1'b1;
    end else begin
      rnd_res = {sign_q, exp_rnd[EW-1:0], mant_sum[MW-1:0]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = S_UNPACK;
      S_UNPACK:    state_nxt = spec_hit ? S_DONE : S_DIVIDE;
      S_DIVIDE:    if (iter == LAST_ITER) state_nxt = S_NORMALIZE;
      S_NORMALIZE: state_nxt = S_ROUND;
      S_ROUND:     state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE) && (state != S_DONE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_a <= '0; op_b <= '0; rm_q <= '0; sign_q <= 1'b0; exp_q <= '0;
      man_b <= '0; rem <= '0; quo <= '0; iter <= '0; mant <= '0;
      guard <= 1'b0; rnd <= 1'b0; sticky <= 1'b0; result <= '0;
      flag_nv <= 1'b0; flag_dz <= 1'b0; flag_of <= 1'b0; flag_uf <= 1'b0; flag_nx <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_a <= operand_a; op_b <= operand_b; rm_q <= rounding_mode;
          flag_nv <= 1'b0; flag_dz <= 1'b0; flag_of <= 1'b0; flag_uf <= 1'b0; flag_nx <= 1'b0;
        end
        S_UNPACK: begin
          sign_q <= sign_x;
          exp_q  <= exp_diff;
          rem    <= {1'b0, 1'b1, frac_a};
          man_b  <= {1'b1, frac_b};
          quo    <= '0;
          iter   <= '0;
          if (spec_hit) begin
            result  <= spec_res;
            flag_nv <= spec_nv;
            flag_dz <= spec_dz;
          end
        end
        S_DIVIDE: begin
          rem  <= rem_sub << 1;
          quo  <= {quo[QW-2:0], rem_ge};
          iter <= iter + 1'b1;
        end
        // Quotient lies in [0.5, 2): a clear MSB means one extra left shift
        S_NORMALIZE: begin
          if (quo[QW-1]) begin
            mant <= quo[QW-2:3]; guard <= quo[2]; rnd <= quo[1]; sticky <= quo[0] | (|rem);
          end else begin
            mant <= quo[QW-3:2]; guard <= quo[1]; rnd <= quo[0]; sticky <= |rem;
            exp_q <= exp_q - ONE_X;
          end
        end
        S_ROUND: begin
          result  <= rnd_res;
          flag_of <= rnd_of;
          flag_uf <= rnd_uf;
          flag_nx <= rnd_nx;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_divider.sv
// Bench for fp_divider (FLEN=32): directed cases with fixed expectations, then random
// operands checked against an integer-arithmetic reference of the IEEE division rules.
module tb_fp_divider;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  rounding_mode = 3'd0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        busy, done;
  logic [31:0] result;
  logic        flag_nv, flag_dz, flag_of, flag_uf, flag_nx;

  int n_checks = 0;
  int n_pass   = 0;
  // {special, nv, dz, of, uf, nx, result}
  logic [37:0] exp_q[$];

  fp_divider #(.FLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rounding_mode(rounding_mode),
    .operand_a(operand_a), .operand_b(operand_b), .busy(busy), .done(done),
    .result(result), .flag_nv(flag_nv), .flag_dz(flag_dz), .flag_of(flag_of),
    .flag_uf(flag_uf), .flag_nx(flag_nx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  function automatic logic [37:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] rm);
    logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, g, rr, st, inx, inc, to_inf;
    int ea, eb, e, lead;
    longint unsigned ma, mb, q, r, man, m;
    s  = a[31] ^ b[31];
    ea = a[30:23];
    eb = b[30:23];
    a_nan = (ea == 255) && (a[22:0] != 0);
    b_nan = (eb == 255) && (b[22:0] != 0);
    a_inf = (ea == 255) && (a[22:0] == 0);
    b_inf = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if ((a_nan && !a[22]) || (b_nan && !b[22])) return {1'b1, 5'b10000, 32'h7FC00000};
    if (a_nan || b_nan) return {1'b1, 5'b00000, 32'h7FC00000};
    if ((a_zero && b_zero) || (a_inf && b_inf)) return {1'b1, 5'b10000, 32'h7FC00000};
    if (a_inf) return {1'b1, 5'b00000, s, 8'hFF, 23'h0};
    if (b_zero) return {1'b1, 5'b01000, s, 8'hFF, 23'h0};
    if (a_zero || b_inf) return {1'b1, 5'b00000, s, 31'h0};
    // Exact integer quotient with plenty of fraction bits; the remainder feeds sticky
    ma = 64'(a[22:0]) | 64'h800000;
    mb = 64'(b[22:0]) | 64'h800000;
    q  = (ma << 40) / mb;
    r  = (ma << 40) % mb;
    lead = q[40] ? 40 : 39;
    e    = ea - eb + 127 + lead - 40;
    man  = (q >> (lead - 23)) & 64'h7FFFFF;
    g    = q[lead - 24];
    rr   = q[lead - 25];
    st   = ((q & ((64'd1 << (lead - 25)) - 64'd1)) != 0) || (r != 0);
    if (e < 1) return {1'b0, 5'b00011, s, 31'h0};
    inx = g | rr | st;
    case (rm)
      3'd0:    inc = g & (rr | st | man[0]);
      3'd2:    inc = s & inx;
      3'd3:    inc = !s & inx;
      3'd4:    inc = g;
      default: inc = 1'b0;
    endcase
    m = man + 64'(inc);
    if (m == 64'h800000) begin
      m = 0;
      e++;
    end
    if (e >= 255) begin
      to_inf = (rm == 3'd0) || (rm == 3'd4) || (rm == 3'd3 && !s) || (rm == 3'd2 && s);
      return {1'b0, 5'b00101, to_inf ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF}};
    end
    return {1'b0, 4'b0000, inx, s, 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic        s    = 1'($urandom_range(0, 1));
    logic [22:0] frac = 23'($urandom());
    case ($urandom_range(0, 11))
      0:       return {s, 31'h0};
      1:       return {s, 8'hFF, 23'h0};
      2:       return {s, 8'hFF, 1'b1, frac[21:0]};
      3:       return {s, 8'hFF, 1'b0, frac[21:0] | 22'h1};
      4:       return {s, 8'h00, frac | 23'h1};
      5:       return {s, 8'($urandom_range(1, 8)), frac};
      6:       return {s, 8'($urandom_range(245, 254)), frac};
      7:       return {s, 8'($urandom_range(120, 134)), frac & 23'h7F0000};
      default: return {s, 8'($urandom_range(64, 190)), frac};
    endcase
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
    @(posedge clk); #1;
    operand_a = a; operand_b = b; rounding_mode = rm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges after the start-sampling edge until done; 100 means it never came
  task automatic wait_done(output int n, output logic busy_ok);
    busy_ok = busy;
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                        input logic [37:0] expv);
    int n;
    logic bok;
    logic [37:0] e;
    exp_q.push_back(expv);
    issue(a, b, rm);
    wait_done(n, bok);
    e = exp_q.pop_front();
    check("latency", 64'(n), e[37] ? 64'd1 : 64'd30);
    check("busy", 64'(bok), 64'd1);
    check("result", 64'(result), 64'(e[31:0]));
    check("flags", 64'({flag_nv, flag_dz, flag_of, flag_uf, flag_nx}), 64'(e[36:32]));
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    int n, dones;
    logic [31:0] ra, rb;
    logic [2:0]  rrm;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'({flag_nv, flag_dz, flag_of, flag_uf, flag_nx}), 64'd0);
    reset_n = 1'b1;

    run_op(32'h40C00000, 32'h40000000, 3'd0, {1'b0, 5'b00000, 32'h40400000});
    run_op(32'h3F800000, 32'h40400000, 3'd0, {1'b0, 5'b00001, 32'h3EAAAAAB});
    run_op(32'h3F800000, 32'h40400000, 3'd1, {1'b0, 5'b00001, 32'h3EAAAAAA});
    run_op(32'h3F800000, 32'h40400000, 3'd4, {1'b0, 5'b00001, 32'h3EAAAAAB});
    run_op(32'h3F800000, 32'h40400000, 3'd3, {1'b0, 5'b00001, 32'h3EAAAAAB});
    run_op(32'hBF800000, 32'h40400000, 3'd2, {1'b0, 5'b00001, 32'hBEAAAAAB});
    run_op(32'h3F800000, 32'h00000000, 3'd0, {1'b1, 5'b01000, 32'h7F800000});
    run_op(32'hBF800000, 32'h00000000, 3'd0, {1'b1, 5'b01000, 32'hFF800000});
    run_op(32'h00000000, 32'h00000000, 3'd0, {1'b1, 5'b10000, 32'h7FC00000});
    run_op(32'h7F800001, 32'h3F800000, 3'd0, {1'b1, 5'b10000, 32'h7FC00000});
    run_op(32'h7FC00001, 32'h3F800000, 3'd0, {1'b1, 5'b00000, 32'h7FC00000});
    run_op(32'h7F000000, 32'h3E800000, 3'd0, {1'b0, 5'b00101, 32'h7F800000});
    run_op(32'h7F000000, 32'h3E800000, 3'd1, {1'b0, 5'b00101, 32'h7F7FFFFF});
    run_op(32'hFF000000, 32'h3E800000, 3'd3, {1'b0, 5'b00101, 32'hFF7FFFFF});
    run_op(32'hFF000000, 32'h3E800000, 3'd2, {1'b0, 5'b00101, 32'hFF800000});
    run_op(32'h00800000, 32'h40000000, 3'd0, {1'b0, 5'b00011, 32'h00000000});
    run_op(32'h40C00000, 32'h40000000, 3'd0, {1'b0, 5'b00000, 32'h40400000});

    // A second start during DIVIDE must be ignored
    issue(32'h40C00000, 32'h40000000, 3'd0);
    n = 0;
    repeat (5) begin @(posedge clk); #1; n++; end
    operand_a = 32'h3F800000; operand_b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1; n++;
    start = 1'b0;
    while (n < 100 && !done) begin @(posedge clk); #1; n++; end
    check("mid_start_latency", 64'(n), 64'd30);
    check("mid_start_result", 64'(result), 64'h40400000);
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dones++; end
    check("mid_start_extra_done", 64'(dones), 64'd0);

    // Reset in the middle of an operation aborts it without a done pulse
    issue(32'h3F800000, 32'h40400000, 3'd0);
    repeat (9) @(posedge clk);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_flags", 64'({flag_nv, flag_dz, flag_of, flag_uf, flag_nx}), 64'd0);
    dones = 0;
    repeat (3) begin @(posedge clk); #1; if (done) dones++; end
    reset_n = 1'b1;
    repeat (30) begin @(posedge clk); #1; if (done) dones++; end
    check("abort_no_done", 64'(dones), 64'd0);
    run_op(32'h40C00000, 32'h40000000, 3'd0, {1'b0, 5'b00000, 32'h40400000});

    for (int i = 0; i < 150; i++) begin
      ra  = rand_fp();
      rb  = rand_fp();
      rrm = 3'($urandom_range(0, 7));
      run_op(ra, rb, rrm, ref_div(ra, rb, rrm));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fp_divider.md
Name: fp_divider

Overview:
- Multi-cycle IEEE 754 floating-point divider implementing FDIV.S (FLEN=32) and FDIV.D (FLEN=64).
- It is the inverse-operation companion to the FPU multiplier and uses the same start/busy/done handshake.
- The mantissa quotient is produced with a radix-2 restoring divider, one quotient bit per cycle.
- It sits in the FPU execute stage alongside the other multi-cycle FP units.

Parameters:
FLEN, 32, operand width: 32 for single precision, 64 for double. Derived: EXP_WIDTH 8/11, MAN_WIDTH 23/52, BIAS 127/1023, MAX_EXP 255/2047.

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE.
rounding_mode  input  3  RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100; others are treated as RTZ.
busy  output  1  high when state is neither IDLE nor DONE.
done  output  1  one-cycle pulse, high while in DONE.
operand_a  input  FLEN  dividend; latched when start is accepted.
operand_b  input  FLEN  divisor; latched when start is accepted.
result  output  FLEN  quotient; holds its value until the next operation writes it.
flag_nv  output  1  invalid operation.
flag_dz  output  1  divide by zero.
flag_of  output  1  overflow.
flag_uf  output  1  underflow.
flag_nx  output  1  inexact.

Behaviour:
Reset and handshake:
- On reset, state=IDLE and result, all flags and all internal registers are cleared to 0.
- Reset asserted mid-operation aborts immediately; no done pulse is produced.
- start is ignored in every state except IDLE.
- Accepting start latches both operands and clears all five flags.

States:
- IDLE -> UNPACK on start.
- UNPACK -> DONE if a special case is detected, otherwise -> DIVIDE.
- DIVIDE runs MAN_WIDTH+4 iterations, driven by an iteration counter.
- DIVIDE -> NORMALIZE -> ROUND -> DONE -> IDLE.

Latency, counted from the edge that samples start:
- done is high after edge MAN_WIDTH+7 (30 for FLEN=32, 59 for FLEN=64).
- For special cases, done is high after edge 1.

Unpack:
- sign = sign_a XOR sign_b.
- Subnormal inputs are treated as signed zero (DAZ); flag_nx is not raised for this.
- Mantissas are {1,frac}, MAN_WIDTH+1 bits.
- exp_q = exp_a - exp_b + BIAS, computed signed in EXP_WIDTH+2 bits.

Special cases, in priority order:
1. Either input sNaN (exp all 1, frac MSB 0, frac != 0) -> canonical NaN, flag_nv.
2. Either input qNaN -> canonical NaN, no flags.
3. 0/0 or inf/inf -> canonical NaN, flag_nv.
4. inf/finite -> ±inf.
5. Finite nonzero / 0 -> ±inf, flag_dz.
6. 0/nonzero or finite/inf -> ±0.
- Canonical NaN is 0x7FC00000 or 0x7FF8000000000000.

Divide:
- Initialise rem = man_a (MAN_WIDTH+2 bits).
- Each cycle: if rem >= man_b, set the q bit to 1 and rem -= man_b; then rem <<= 1.
- The quotient has MAN_WIDTH+4 bits; its MSB has weight 2^0.

Normalize:
- If q MSB = 0 (man_a < man_b): shift q left 1 and decrement exp_q.
- Mantissa = next MAN_WIDTH bits below the leading 1.
- guard and round are the following two bits.
- sticky = OR of any remaining quotient bits OR (rem != 0).

Round:
- RNE: increment when G and (R or S or lsb).
- RTZ: never increment.
- RDN: increment when sign and (G|R|S).
- RUP: increment when !sign and (G|R|S).
- RMM: increment when G.
- A mantissa carry-out increments the exponent.
- flag_nx = G|R|S.

Overflow (final exponent >= MAX_EXP):
- Set flag_of and flag_nx.
- Result is ±inf for RNE and RMM, RUP positive, RDN negative.
- Otherwise the result is ±max finite (0x7F7FFFFF for single).

Underflow (exponent before rounding < 1):
- Result is ±0 (flush to zero), with flag_uf and flag_nx.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2), RNE -> 0x40400000, no flags; done high exactly 30 cycles after start; busy high for cycles 1-29.
- 0x3F800000 / 0x40400000 (1/3): RNE -> 0x3EAAAAAB with flag_nx; RTZ -> 0x3EAAAAAA with flag_nx.
- Special cases, each with done 1 cycle after start:
  - 0x3F800000 / 0x00000000 -> 0x7F800000, flag_dz.
  - 0xBF800000 / 0x00000000 -> 0xFF800000, flag_dz.
  - 0/0 -> 0x7FC00000, flag_nv.
  - 0x7F800001 / 1.0 -> 0x7FC00000, flag_nv.
  - 0x7FC00001 / 1.0 -> 0x7FC00000, no flags.
- 0x7F000000 / 0x3E800000: RNE -> 0x7F800000 with flag_of and flag_nx; RTZ -> 0x7F7FFFFF with flag_of and flag_nx.
- 0x00800000 / 0x40000000 -> 0x00000000 with flag_uf and flag_nx.
- Back-to-back operations clear the previous flags.
- start pulsed during DIVIDE is ignored: the first result is unchanged and there is no extra done.
- reset_n low at cycle 10 -> busy=0, result=0, no done; the next op runs normally.
